prog_counter: RTL and testbench
===============================

Name: prog_counter

Overview:
Parametrised up/down counter, successor to the fixed 8-bit enable counter.
- Configurable width, terminal value and prescale ratio.
- Wrap or saturate mode, synchronous load and clear.
- Registered terminal-count pulse and sticky overflow flag.
- Used as a general event/timing counter wherever a modulo-N or bounded count is needed in the datapath.

Parameters:
WIDTH, 8, counter width in bits (>=1)
MAX_VALUE, 2**WIDTH-1, terminal (upper) count value; legal range 1..2**WIDTH-1
PRESCALE, 1, enabled cycles per count step (>=1); 1 = step every enabled cycle
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count enable; qualifies prescaler advance
up_down  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
load_value  input  WIDTH  value loaded on load
clear  input  1  synchronous clear of count, prescaler and overflow
count  output  WIDTH  registered counter value
nonzero  output  1  combinational OR-reduce of count
tc  output  1  registered terminal-count pulse, one cycle
overflow  output  1  sticky boundary-hit flag

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: count=0, tc=0, overflow=0, prescaler=0. Reset mid-operation takes effect on the next rising edge and overrides every other input.
- Priority per edge: reset > clear > load > step.
- clear: count=0, prescaler=0, overflow=0, tc=0.
- load: count=min(load_value, MAX_VALUE), prescaler=0, tc=0, overflow unchanged. Load with enable in the same cycle: load wins, no step.
- Prescaler: internal counter, $clog2(PRESCALE) bits (none when PRESCALE=1).
  - Advances only when enable=1 and no load/clear.
  - Step event when enable=1 and prescaler==PRESCALE-1; prescaler then returns to 0.
  - enable=0 freezes both the prescaler and count.
- Step, up (up_down=1):
  - count<MAX_VALUE: count+1.
  - count==MAX_VALUE: boundary event. Result is 0 if SATURATE=0, MAX_VALUE if SATURATE=1.
- Step, down (up_down=0):
  - count>0: count-1.
  - count==0: boundary event. Result is MAX_VALUE if SATURATE=0, 0 if SATURATE=1.
- Boundary event effects:
  - tc=1 for exactly the following cycle.
  - overflow set and held until clear/reset.
  - Repeated saturated steps each pulse tc again.
- tc=0 in every cycle not following a boundary event.
- Direction may change on any cycle; it is sampled at the step edge only.
- count is never outside 0..MAX_VALUE. Arithmetic is WIDTH bits, with boundaries detected by compare, not carry.
- Step latency: count updates on the edge where the step condition is sampled; tc/overflow update on that same edge.
- nonzero is purely combinational from count.
- Illegal parameters (MAX_VALUE=0, MAX_VALUE>2**WIDTH-1, PRESCALE=0) are flagged by an elaboration-time check.

Optional Feature:
COUNTER_COMPARE_EN
- Defined: adds input compare_value [WIDTH] and output match [1]. match is registered, reset 0, and equals (next count == compare_value) each cycle, so it is aligned with count.
- Undefined: compare_value and match ports are absent; no compare logic is generated.

Test Plan:
- WIDTH=8 defaults: reset, then enable=1, up_down=1 for 256 cycles -> count 0..255 then 0; tc=1 one cycle after the 255->0 edge; overflow=1 thereafter.
- MAX_VALUE=9, SATURATE=1, up: 12 enabled cycles -> count holds at 9; tc pulses on cycles 10, 11 and 12; clear -> count=0, overflow=0.
- MAX_VALUE=9, SATURATE=0, down from 0 -> count=9, tc=1; load_value=200 -> count=9 (clamped).
- PRESCALE=4, enable toggling 1,1,0,1,1 -> count increments once after the 4th enabled cycle; enable=0 cycles do not advance the prescaler.
- Simultaneous reset=1, load=1, clear=1 at count=5 -> count=0, overflow=0; then load=1, enable=1, load_value=7 -> count=7, no step, tc=0.
- COUNTER_COMPARE_EN, compare_value=3, counting up from 0 -> match=1 exactly in the cycle count==3, and 0 otherwise.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: parametrised up/down counter with prescaler, wrap/saturate, tc pulse, sticky overflow.
// Optional COUNTER_COMPARE_EN adds compare_value input and registered match output.
module prog_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 2**WIDTH-1,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
`ifdef COUNTER_COMPARE_EN
    input  logic [WIDTH-1:0] compare_value,
    output logic             match,
`endif
    output logic [WIDTH-1:0] count,
    output logic             nonzero,
    output logic             tc,
    output logic             overflow
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic step, bnd, hit;
    logic [WIDTH-1:0] stepped, loaded, nxt;
    generate
        if (MAX_VALUE < 1 || MAX_VALUE > 2**WIDTH-1 || PRESCALE < 1) begin : g_bad
            $error("prog_counter: illegal MAX_VALUE or PRESCALE");
        end
        if (PRESCALE == 1) begin : g_nopre
            assign step = enable;
        end else begin : g_pre
            logic [PW-1:0] pre;
            assign step = enable && pre == PW'(PRESCALE-1);
            always_ff @(posedge clk) begin
                if (reset || clear || load)
                    pre <= '0;
                else if (enable)
                    pre <= step ? '0 : pre + 1'b1;
            end
        end
    endgenerate
    // Boundaries come from compares so count never leaves 0..MAX_VALUE
    always_comb begin
        bnd = up_down ? count == MAXV : count == '0;
        stepped = up_down ? (bnd ? (SATURATE != 0 ? MAXV : '0) : count + 1'b1)
                          : (bnd ? (SATURATE != 0 ? '0 : MAXV) : count - 1'b1);
        loaded = load_value > MAXV ? MAXV : load_value;
        hit = !clear && !load && step && bnd;
        nxt = clear ? '0 : load ? loaded : step ? stepped : count;
    end
    assign nonzero = |count;
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count    <= nxt;
            tc       <= hit;
            overflow <= !clear && (overflow || hit);
        end
    end
`ifdef COUNTER_COMPARE_EN
    always_ff @(posedge clk) match <= !reset && nxt == compare_value;
`endif
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: randomized check of three prog_counter configurations against an integer model.
module tb_prog_counter;
    logic clk = 0, reset = 1, enable = 0, up_down = 1, load = 0, clear = 0;
    logic [7:0] load_value = 0, compare_value = 0;
    logic [7:0] q [3];
    logic nz [3], tco [3], ovo [3], mo [3];
    int mx [3] = '{255, 9, 9};
    int ps [3] = '{1, 1, 4};
    int sat [3] = '{0, 1, 0};
    int cnt [3], pre [3], tcm [3], ovm [3], mt [3];
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : u
        prog_counter #(.WIDTH(8), .MAX_VALUE(g == 0 ? 255 : 9), .PRESCALE(g == 2 ? 4 : 1),
                       .SATURATE(g == 1 ? 1 : 0)) dut (
            .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
            .load_value(load_value), .clear(clear),
`ifdef COUNTER_COMPARE_EN
            .compare_value(compare_value), .match(mo[g]),
`endif
            .count(q[g]), .nonzero(nz[g]), .tc(tco[g]), .overflow(ovo[g]));
`ifndef COUNTER_COMPARE_EN
        assign mo[g] = 1'b0;
`endif
    end
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic model(input int i);
        bit hit;
        tcm[i] = 0;
        if (reset) begin
            cnt[i] = 0; pre[i] = 0; ovm[i] = 0;
        end else if (clear) begin
            cnt[i] = 0; pre[i] = 0; ovm[i] = 0;
        end else if (load) begin
            cnt[i] = int'(load_value) < mx[i] ? int'(load_value) : mx[i];
            pre[i] = 0;
        end else if (enable) begin
            pre[i]++;
            if (pre[i] == ps[i]) begin
                pre[i] = 0;
                hit = up_down ? cnt[i] == mx[i] : cnt[i] == 0;
                if (hit) cnt[i] = (up_down ^ (sat[i] != 0)) ? 0 : mx[i];
                else cnt[i] = up_down ? cnt[i] + 1 : cnt[i] - 1;
                tcm[i] = hit;
                ovm[i] = ovm[i] | hit;
            end
        end
        mt[i] = reset ? 0 : cnt[i] == int'(compare_value);
    endtask
    task automatic cycle(input bit r, input bit c, input bit l, input int lv, input bit e, input bit ud);
        reset = r; clear = c; load = l; load_value = 8'(lv); enable = e; up_down = ud;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model(i);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("count%0d", i), int'(q[i]), cnt[i]);
            check($sformatf("nonzero%0d", i), int'(nz[i]), int'(cnt[i] != 0));
            check($sformatf("tc%0d", i), int'(tco[i]), tcm[i]);
            check($sformatf("overflow%0d", i), int'(ovo[i]), ovm[i]);
`ifdef COUNTER_COMPARE_EN
            check($sformatf("match%0d", i), int'(mo[i]), mt[i]);
`endif
        end
    endtask
    initial begin
        cycle(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 258; k++) cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 200, 1, 1);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, k != 2, 1);
        cycle(0, 0, 1, 5, 0, 1);
        cycle(1, 1, 1, 5, 1, 1);
        cycle(0, 0, 1, 7, 1, 1);
        for (int k = 0; k < 3000; k++) begin
            compare_value = 8'($urandom_range(0, 12));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 255), $urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
